// File: rtl/usb_tx.sv
// usb_tx: USB full-speed transmitter. Frames SYNC/PID/payload/CRC16, bit-stuffs,
// NRZI-encodes and appends EOP, using 8/8/9-clock bit periods from a 100 MHz clock.
//   state   | meaning
//   IDLE    | bus at J, sampling TX_packet
//   SYNC    | sending 0000_0001
//   PID     | sending {pid, ~pid}
//   DATA    | sending a payload byte
//   CRC_HI  | sending complemented CRC16 [15:8]
//   CRC_LO  | sending complemented CRC16 [7:0]
//   EOP_SE0 | two bit periods of SE0
//   EOP_J   | one bit period of J
module usb_tx #(
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BYTES  = 64,
  parameter int OCC_WIDTH  = 7
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic [2:0]            TX_packet,
  input  logic [OCC_WIDTH-1:0]  buffer_occupancy,
  input  logic [DATA_WIDTH-1:0] TX_packet_data,
  output logic                  get_TX_packet_data,
  output logic                  d_plus,
  output logic                  d_minus,
  output logic                  TX_transfer_active,
  output logic                  TX_error
);

  typedef enum logic [2:0] {
    IDLE, SYNC, PID, DATA, CRC_HI, CRC_LO, EOP_SE0, EOP_J
  } state_t;

  localparam logic [OCC_WIDTH-1:0] MAX_N = OCC_WIDTH'(MAX_BYTES);
  localparam logic [2:0]           LAST_BIT = 3'(DATA_WIDTH - 1);

  state_t                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [1:0]            ph_q, ph_d, ph_nx;
  logic [DATA_WIDTH-1:0] sh_q, sh_d;
  logic [2:0]            bcnt_q, bcnt_d;
  logic [2:0]            ones_q, ones_d;
  logic [2:0]            ptype_q, ptype_d;
  logic [OCC_WIDTH-1:0]  rem_q, rem_d;
  logic                  have_q, have_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [15:0]           crc_q, crc_d;
  logic                  rd_pend_q, rd_pend_d;
  logic                  get_q, get_d;
  logic                  err_q, err_d;
  logic                  active_q, active_d;
  logic                  dp_q, dp_d;
  logic                  dm_q, dm_d;

  logic                  drive, tx_bit, to_eop, is_data, reject;
  logic [DATA_WIDTH-1:0] nbyte, pid_byte;

  function automatic logic [3:0] pid_of(input logic [2:0] t);
    case (t)
      3'd1:    pid_of = 4'b0011;
      3'd2:    pid_of = 4'b1011;
      3'd3:    pid_of = 4'b0010;
      3'd4:    pid_of = 4'b1010;
      default: pid_of = 4'b1110;
    endcase
  endfunction

  function automatic logic [15:0] crc_upd(input logic [15:0] c, input logic [DATA_WIDTH-1:0] b);
    logic [15:0] r;
    r = c;
    for (int i = DATA_WIDTH - 1; i >= 0; i--) begin
      if (r[15] ^ b[i]) r = {r[14:0], 1'b0} ^ 16'h8005;
      else              r = {r[14:0], 1'b0};
    end
    return r;
  endfunction

  assign pid_byte = {pid_of(ptype_q), ~pid_of(ptype_q)};
  assign is_data  = (TX_packet == 3'd1) || (TX_packet == 3'd2);
  assign reject   = (TX_packet == 3'd6) || (TX_packet == 3'd7) ||
                    (is_data && (buffer_occupancy > MAX_N));
  assign ph_nx    = (ph_q == 2'd2) ? 2'd0 : ph_q + 2'd1;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ph_d      = ph_q;
    sh_d      = sh_q;
    bcnt_d    = bcnt_q;
    ones_d    = ones_q;
    ptype_d   = ptype_q;
    rem_d     = rem_q;
    have_d    = have_q;
    data_d    = data_q;
    crc_d     = crc_q;
    rd_pend_d = get_q;
    get_d     = 1'b0;
    err_d     = 1'b0;
    active_d  = active_q;
    dp_d      = dp_q;
    dm_d      = dm_q;
    drive     = 1'b0;
    tx_bit    = 1'b1;
    to_eop    = 1'b0;
    nbyte     = '0;

    // Buffer data is valid the clock after the pop; CRC folds in each byte as it lands.
    if (rd_pend_q) begin
      data_d = TX_packet_data;
      crc_d  = crc_upd(crc_q, TX_packet_data);
    end

    case (state_q)
      IDLE: begin
        if (TX_packet != 3'd0) begin
          if (reject) begin
            err_d = 1'b1;
          end else begin
            state_d  = SYNC;
            active_d = 1'b1;
            cnt_d    = 4'd7;
            ph_d     = 2'd0;
            sh_d     = DATA_WIDTH'(1);
            bcnt_d   = 3'd0;
            ptype_d  = TX_packet;
            rem_d    = is_data ? buffer_occupancy : '0;
            have_d   = 1'b0;
            crc_d    = 16'hFFFF;
            tx_bit   = 1'b0;
            drive    = 1'b1;
          end
        end
      end
      default: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          ph_d  = ph_nx;
          cnt_d = (ph_nx == 2'd2) ? 4'd8 : 4'd7;
          case (state_q)
            EOP_SE0: begin
              if (bcnt_q == 3'd0) begin
                bcnt_d = 3'd1;
              end else begin
                state_d = EOP_J;
                dp_d    = 1'b1;
                dm_d    = 1'b0;
              end
            end
            EOP_J: begin
              state_d  = IDLE;
              active_d = 1'b0;
            end
            default: begin
              if (ones_q == 3'd6) begin
                // Stuffed bit: pointers hold, so the next real bit slips one period.
                tx_bit = 1'b0;
                drive  = 1'b1;
              end else if (bcnt_q != LAST_BIT) begin
                sh_d   = {sh_q[DATA_WIDTH-2:0], 1'b0};
                bcnt_d = bcnt_q + 3'd1;
                tx_bit = sh_q[DATA_WIDTH-2];
                drive  = 1'b1;
                if ((bcnt_q == LAST_BIT - 3'd1) && ((state_q == PID) || (state_q == DATA)) &&
                    (rem_q != '0)) begin
                  get_d  = 1'b1;
                  rem_d  = rem_q - OCC_WIDTH'(1);
                  have_d = 1'b1;
                end
              end else begin
                bcnt_d = 3'd0;
                case (state_q)
                  SYNC: begin
                    state_d = PID;
                    nbyte   = pid_byte;
                  end
                  PID, DATA: begin
                    if (ptype_q >= 3'd3) begin
                      to_eop = 1'b1;
                    end else if (have_q) begin
                      state_d = DATA;
                      nbyte   = data_q;
                      have_d  = 1'b0;
                    end else begin
                      state_d = CRC_HI;
                      nbyte   = ~crc_q[15:8];
                    end
                  end
                  CRC_HI: begin
                    state_d = CRC_LO;
                    nbyte   = ~crc_q[7:0];
                  end
                  default: to_eop = 1'b1;
                endcase
                if (to_eop) begin
                  state_d = EOP_SE0;
                  dp_d    = 1'b0;
                  dm_d    = 1'b0;
                end else begin
                  sh_d   = nbyte;
                  tx_bit = nbyte[DATA_WIDTH-1];
                  drive  = 1'b1;
                end
              end
            end
          endcase
        end
      end
    endcase

    if (drive) begin
      ones_d = tx_bit ? ones_q + 3'd1 : 3'd0;
      dp_d   = tx_bit ? dp_q : ~dp_q;
      dm_d   = tx_bit ? ~dp_q : dp_q;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      ph_q      <= '0;
      sh_q      <= '0;
      bcnt_q    <= '0;
      ones_q    <= '0;
      ptype_q   <= '0;
      rem_q     <= '0;
      have_q    <= 1'b0;
      data_q    <= '0;
      crc_q     <= 16'hFFFF;
      rd_pend_q <= 1'b0;
      get_q     <= 1'b0;
      err_q     <= 1'b0;
      active_q  <= 1'b0;
      dp_q      <= 1'b1;
      dm_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ph_q      <= ph_d;
      sh_q      <= sh_d;
      bcnt_q    <= bcnt_d;
      ones_q    <= ones_d;
      ptype_q   <= ptype_d;
      rem_q     <= rem_d;
      have_q    <= have_d;
      data_q    <= data_d;
      crc_q     <= crc_d;
      rd_pend_q <= rd_pend_d;
      get_q     <= get_d;
      err_q     <= err_d;
      active_q  <= active_d;
      dp_q      <= dp_d;
      dm_q      <= dm_d;
    end
  end

  assign get_TX_packet_data = get_q;
  assign d_plus             = dp_q;
  assign d_minus            = dm_q;
  assign TX_transfer_active = active_q;
  assign TX_error           = err_q;

endmodule

// File: tb/tb_usb_tx.sv
// Bench for usb_tx: directed plus randomized packets compared cycle-by-cycle against a
// line-level model built from the framing, CRC long-division, stuffing and NRZI rules.
module tb_usb_tx;

  logic       clk = 1'b0;
  logic       n_rst;
  logic [2:0] TX_packet;
  logic [6:0] buffer_occupancy;
  logic [7:0] TX_packet_data;
  logic       get_TX_packet_data, d_plus, d_minus, TX_transfer_active, TX_error;

  int total = 0;
  int bad   = 0;

  logic [7:0] pay      [$];
  logic [1:0] per_line [$];
  int         raw_per  [$];

  usb_tx dut (
    .clk                (clk),
    .n_rst              (n_rst),
    .TX_packet          (TX_packet),
    .buffer_occupancy   (buffer_occupancy),
    .TX_packet_data     (TX_packet_data),
    .get_TX_packet_data (get_TX_packet_data),
    .d_plus             (d_plus),
    .d_minus            (d_minus),
    .TX_transfer_active (TX_transfer_active),
    .TX_error           (TX_error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint obs, input longint exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int pstart(input int p);
    return 25 * (p / 3) + 8 * (p % 3);
  endfunction

  // Expected line state per bit period for packet `code` carrying `pay`.
  task automatic build(input int code);
    logic [7:0]  bytes [$];
    logic        a     [$];
    logic [16:0] poly;
    logic [15:0] crc;
    logic [3:0]  pid;
    logic        lvl;
    int          run;
    poly = 17'h18005;
    raw_per.delete();
    per_line.delete();
    case (code)
      1:       pid = 4'b0011;
      2:       pid = 4'b1011;
      3:       pid = 4'b0010;
      4:       pid = 4'b1010;
      default: pid = 4'b1110;
    endcase
    bytes.push_back(8'h01);
    bytes.push_back({pid, ~pid});
    if (code <= 2) begin
      foreach (pay[i]) bytes.push_back(pay[i]);
      // remainder of (M*x^16 + FFFF*x^len) mod P, then complemented
      foreach (pay[i]) for (int b = 7; b >= 0; b--) a.push_back(pay[i][b]);
      for (int i = 0; i < 16; i++) a.push_back(1'b0);
      for (int i = 0; i < 16; i++) a[i] = ~a[i];
      for (int i = 0; i < a.size() - 16; i++)
        if (a[i]) for (int j = 0; j < 17; j++) a[i+j] = a[i+j] ^ poly[16-j];
      for (int i = 0; i < 16; i++) crc[15-i] = a[a.size() - 16 + i];
      crc = ~crc;
      bytes.push_back(crc[15:8]);
      bytes.push_back(crc[7:0]);
    end
    run = 0;
    lvl = 1'b1;
    foreach (bytes[k]) for (int b = 7; b >= 0; b--) begin
      raw_per.push_back(per_line.size());
      if (!bytes[k][b]) lvl = ~lvl;
      per_line.push_back({lvl, ~lvl});
      run = bytes[k][b] ? run + 1 : 0;
      if (run == 6) begin
        lvl = ~lvl;
        per_line.push_back({lvl, ~lvl});
        run = 0;
      end
    end
    per_line.push_back(2'b00);
    per_line.push_back(2'b00);
    per_line.push_back(2'b10);
  endtask

  // Requests a packet and checks every clock; stop_at >= 0 ends early after that cycle.
  task automatic run_packet(input string tag, input int code, input int stop_at);
    bit   exp_get [int];
    int   P, T, ncyc, rd, cur_p;
    int   line_err, act_err, act_cnt, gets, get_err, err_cnt;
    logic pend;
    logic [1:0] el;
    logic ea;
    build(code);
    P = per_line.size();
    T = pstart(P);
    if (code <= 2) for (int k = 0; k < pay.size(); k++) exp_get[pstart(raw_per[15 + 8*k])] = 1'b1;
    ncyc = (stop_at >= 0) ? stop_at + 1 : T + 12;
    TX_packet        = code[2:0];
    buffer_occupancy = (code <= 2) ? 7'(pay.size()) : 7'($urandom);
    TX_packet_data   = 8'($urandom);
    @(posedge clk); #1;
    rd = 0; pend = 1'b0; cur_p = 0;
    line_err = 0; act_err = 0; act_cnt = 0; gets = 0; get_err = 0; err_cnt = 0;
    for (int c = 0; c < ncyc; c++) begin
      if (c < 6) begin
        TX_packet        = 3'($urandom_range(1, 7));
        buffer_occupancy = 7'($urandom);
      end else begin
        TX_packet = 3'd0;
      end
      while ((cur_p + 1 < P) && (pstart(cur_p + 1) <= c)) cur_p++;
      el = (c < T) ? per_line[cur_p] : 2'b10;
      ea = (c < T);
      @(negedge clk);
      if ({d_plus, d_minus} !== el) line_err++;
      if (TX_transfer_active !== ea) act_err++;
      if (TX_transfer_active === 1'b1) act_cnt++;
      if (TX_error !== 1'b0) err_cnt++;
      if (get_TX_packet_data === 1'b1) begin
        gets++;
        pend = 1'b1;
        if (!exp_get.exists(c)) get_err++;
      end else if (exp_get.exists(c)) begin
        get_err++;
      end
      @(posedge clk); #1;
      if (pend) begin
        TX_packet_data = (rd < pay.size()) ? pay[rd] : 8'($urandom);
        rd++;
        pend = 1'b0;
      end
    end
    chk({tag, ".lines"}, line_err, 0);
    chk({tag, ".active_shape"}, act_err, 0);
    if (stop_at < 0) begin
      chk({tag, ".active_len"}, act_cnt, T);
      chk({tag, ".get_count"}, gets, (code <= 2) ? pay.size() : 0);
      chk({tag, ".get_pos"}, get_err, 0);
      chk({tag, ".no_error"}, err_cnt, 0);
    end
  endtask

  task automatic run_reject(input string tag, input int code, input int occ);
    int err_cnt, act_cnt, nonj, gets;
    err_cnt = 0; act_cnt = 0; nonj = 0; gets = 0;
    TX_packet        = code[2:0];
    buffer_occupancy = 7'(occ);
    @(posedge clk); #1;
    TX_packet = 3'd0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (TX_error === 1'b1) err_cnt++;
      if (TX_transfer_active !== 1'b0) act_cnt++;
      if ({d_plus, d_minus} !== 2'b10) nonj++;
      if (get_TX_packet_data !== 1'b0) gets++;
    end
    chk({tag, ".err_pulse"}, err_cnt, 1);
    chk({tag, ".active"}, act_cnt, 0);
    chk({tag, ".lines_j"}, nonj, 0);
    chk({tag, ".gets"}, gets, 0);
  endtask

  task automatic fill_pay(input int n, input bit heavy_ones);
    pay.delete();
    for (int i = 0; i < n; i++)
      pay.push_back((heavy_ones && ($urandom_range(0, 3) == 0)) ? 8'hFF : 8'($urandom));
  endtask

  initial begin
    int stop;
    int code;
    n_rst = 1'b0;
    TX_packet = 3'd0;
    buffer_occupancy = '0;
    TX_packet_data = '0;
    #23;
    chk("rst.d_plus", d_plus, 1);
    chk("rst.d_minus", d_minus, 0);
    chk("rst.get", get_TX_packet_data, 0);
    chk("rst.active", TX_transfer_active, 0);
    chk("rst.error", TX_error, 0);
    @(negedge clk);
    n_rst = 1'b1;
    @(posedge clk); #1;

    pay.delete();
    run_packet("ack", 3, -1);
    pay.delete();
    pay.push_back(8'hFF);
    pay.push_back(8'h00);
    run_packet("data0_ff00", 1, -1);
    pay.delete();
    run_packet("data1_empty", 2, -1);

    run_reject("rej_occ65", 1, 65);
    run_reject("rej_code7", 7, 0);
    run_reject("rej_code6", 6, 3);

    fill_pay(64, 1'b1);
    run_packet("data0_max64", 1, -1);

    for (int i = 0; i < 8; i++) begin
      code = $urandom_range(1, 5);
      fill_pay($urandom_range(0, 12), 1'b1);
      run_packet($sformatf("rand%0d", i), code, -1);
    end

    fill_pay(10, 1'b0);
    build(1);
    stop = pstart(raw_per[16 + 16 + 3]) + 2;
    run_packet("rst_mid", 1, stop);
    #2;
    n_rst = 1'b0;
    #1;
    chk("rst_mid.d_plus", d_plus, 1);
    chk("rst_mid.d_minus", d_minus, 0);
    chk("rst_mid.active", TX_transfer_active, 0);
    chk("rst_mid.get", get_TX_packet_data, 0);
    @(negedge clk);
    @(negedge clk);
    n_rst = 1'b1;
    @(posedge clk); #1;
    pay.delete();
    run_packet("nak_after_rst", 4, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/usb_tx.md
Name: usb_tx

Overview:
- USB full-speed transmit path: the transmitting counterpart of USB_RX.
- Accepts a packet-type request from the protocol controller and reads payload bytes from the TX data buffer.
- Drives d_plus/d_minus with SYNC, PID, payload, CRC16, bit stuffing, NRZI encoding and EOP.
- Bit order and encodings are identical to what USB_RX decodes: MSB-first bytes, PID byte = {pid, ~pid}.

Parameters:
- DATA_WIDTH, 8, payload byte width.
- MAX_BYTES, 64, largest legal DATA payload.
- OCC_WIDTH, 7, width of buffer_occupancy.

Ports:
- clk  in  1  system clock, 100 MHz.
- n_rst  in  1  asynchronous active-low reset.
- TX_packet  in  3  request code: 0 IDLE, 1 DATA0, 2 DATA1, 3 ACK, 4 NAK, 5 STALL; 6 and 7 are invalid.
- buffer_occupancy  in  OCC_WIDTH  number of bytes held in the TX buffer.
- TX_packet_data  in  DATA_WIDTH  buffer read data; valid one clock after get_TX_packet_data.
- get_TX_packet_data  out  1  one-clock buffer pop strobe.
- d_plus  out  1  USB D+ line.
- d_minus  out  1  USB D- line.
- TX_transfer_active  out  1  high while a packet is on the bus.
- TX_error  out  1  one-clock pulse on a rejected request.

Behaviour:
- Clock is clk; reset is n_rst, asynchronous, active-low.
- Reset values: d_plus=1, d_minus=0 (J); get_TX_packet_data=0; TX_transfer_active=0; TX_error=0; FSM in IDLE.
- Reset asserted mid-packet forces J and IDLE immediately. No partial EOP is sent.
- FSM states: IDLE, SYNC, PID, DATA, CRC_HI, CRC_LO, EOP_SE0, EOP_J.
- IDLE:
  - TX_packet is sampled only in IDLE.
  - A nonzero code captures the packet type. Code 1 or 2 also captures buffer_occupancy as byte count N.
  - TX_packet changes after capture are ignored.
- Rejected requests: code 6/7, or a DATA request with N > MAX_BYTES.
  - TX_error=1 for exactly one clock.
  - No bus activity, no get pulse; FSM stays in IDLE.
- Bit timing:
  - Bit periods repeat 8, 8, 9 clocks (25 clocks per 3 bits = 12 Mb/s average).
  - The pattern restarts at the first SYNC bit of every packet.
  - Outputs change only on bit-period boundaries.
- Latency: first SYNC bit is driven on the clock after the request is captured. TX_transfer_active rises on that same clock.
- Field order:
  - SYNC 8'b0000_0001, then PID byte {pid, ~pid}.
  - pid values: DATA0 0011, DATA1 1011, ACK 0010, NAK 1010, STALL 1110.
  - Handshakes (ACK/NAK/STALL) go from PID straight to EOP.
  - DATA: N payload bytes, then CRC16 high byte, then low byte. N=0 is legal: PID is followed directly by the CRC.
- CRC16:
  - Polynomial 0x8005, init 0xFFFF, updated MSB-first over payload bytes only.
  - Transmitted value is the bitwise complement of the final register.
  - Zero payload gives CRC 0x0000.
- Buffer reads:
  - get_TX_packet_data pulses for exactly one clock at the start of the last bit period of the PID byte or of the preceding payload byte.
  - TX_packet_data is latched on the following clock; the byte is loaded at the next byte boundary.
  - Exactly N pulses per DATA packet.
- NRZI: a 0 bit toggles both lines; a 1 bit holds them. d_minus = ~d_plus outside EOP.
- Bit stuffing:
  - The ones counter clears at the first SYNC bit.
  - After six consecutive transmitted 1s, one stuffed 0 (toggle) is inserted, taking one full bit period.
  - The stuffed bit resets the counter to 0 and does not count toward the next run.
  - Stuffing applies across byte boundaries and also after the final CRC bit, before EOP.
  - Stuffed bits delay the next get pulse by exactly one bit period.
- EOP: SE0 (d_plus=0, d_minus=0) for 2 bit periods, then J for 1 bit period, then IDLE.
- TX_transfer_active falls on the clock the EOP J period ends. A new request is accepted on that same clock.

Test Plan:
- Reset with lines idle → d_plus=1, d_minus=0, all other outputs 0. Assert n_rst mid-clock → outputs change asynchronously.
- TX_packet=3 (ACK) → NRZI of 0000_0001 0010_1101 then SE0, SE0, J. 19 bit periods, TX_transfer_active high exactly 158 clocks, no get pulse.
- TX_packet=1, occupancy 2, bytes 0xFF,0x00 → PID 0011_1100, one stuffed toggle after the 6th 1 of 0xFF. Exactly 2 get pulses; CRC bytes match the 0x8005 reference model. RX decodes DATA with payload FF 00.
- TX_packet=2, occupancy 0 → PID 1011_0100 then 16 zero bits (16 toggles) then EOP. No get pulse.
- TX_packet=1, occupancy 65; separately TX_packet=7 → TX_error high for one clock each, lines remain J, TX_transfer_active stays 0.
- n_rst low during the 3rd payload byte of a 10-byte DATA0 → J on the bus, FSM in IDLE. A following NAK request transmits correctly with the bit timing restarted.
